// File: rtl/leaf_port_arbiter.sv
// Round-robin, packet-aware arbiter for one leaf switch output port.
// The grant is held from a packet's first beat to its last beat. Winning beats land in a
// single output register, which sustains one beat per cycle with valid/ready on both sides.
module leaf_port_arbiter #(
    parameter int unsigned NUM_IN = 5,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PTR_W  = 3
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [NUM_IN*DATA_W-1:0] i_req_data,
    input  logic [NUM_IN-1:0]        i_req_valid,
    input  logic [NUM_IN-1:0]        i_req_last,
    output logic [NUM_IN-1:0]        o_req_ready,
    output logic [DATA_W-1:0]        o_data,
    output logic                     o_data_valid,
    output logic                     o_data_last,
    input  logic                     i_data_ready,
    output logic [NUM_IN-1:0]        o_grant,
    output logic [31:0]              o_pkt_count
);

    localparam logic [0:0] StIdle   = 1'b0;
    localparam logic [0:0] StLocked = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [PTR_W-1:0]  owner_q, owner_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_q, last_d;
    logic              valid_q, valid_d;
    logic [NUM_IN-1:0] grant_q, grant_d;
    logic [31:0]       cnt_q, cnt_d;

    logic              slot;
    logic              win_found;
    logic [PTR_W-1:0]  win_idx;
    logic [PTR_W:0]    cand;
    logic              sel_en;
    logic [PTR_W-1:0]  sel_idx;
    logic [NUM_IN-1:0] sel_onehot;
    logic [DATA_W-1:0] sel_data;
    logic              sel_valid;
    logic              sel_last;
    logic              xfer;

    assign slot = !valid_q || i_data_ready;

    // Round-robin search: first valid input starting at the pointer, wrapping modulo NUM_IN.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            cand = {1'b0, ptr_q} + (PTR_W+1)'(i);
            if (cand >= (PTR_W+1)'(NUM_IN)) begin
                cand = cand - (PTR_W+1)'(NUM_IN);
            end
            if (!win_found && i_req_valid[cand[PTR_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[PTR_W-1:0];
            end
        end
    end

    // Select the serviced input: the round-robin winner when idle, the packet owner when locked.
    always_comb begin
        sel_en     = (state_q == StLocked) ? 1'b1 : win_found;
        sel_idx    = (state_q == StLocked) ? owner_q : win_idx;
        sel_onehot = '0;
        sel_data   = '0;
        sel_valid  = 1'b0;
        sel_last   = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (PTR_W'(k) == sel_idx) begin
                sel_onehot[k] = 1'b1;
                sel_data      = i_req_data[k*DATA_W +: DATA_W];
                sel_valid     = i_req_valid[k];
                sel_last      = i_req_last[k];
            end
        end
        // Ready is held low during reset so no beat appears accepted upstream.
        o_req_ready = (sel_en && slot && !i_reset) ? sel_onehot : '0;
        xfer        = sel_en && slot && sel_valid && !i_reset;
    end

    // Next state for the arbitration FSM, pointer, packet counter and output register.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        last_d  = last_q;
        valid_d = valid_q;
        grant_d = grant_q;
        if (xfer) begin
            data_d  = sel_data;
            last_d  = sel_last;
            valid_d = 1'b1;
            grant_d = sel_onehot;
            if (sel_last) begin
                state_d = StIdle;
                ptr_d   = (sel_idx == PTR_W'(NUM_IN - 1)) ? '0 : sel_idx + PTR_W'(1);
                cnt_d   = cnt_q + 32'd1;
            end else begin
                state_d = StLocked;
                owner_d = sel_idx;
            end
        end else if (i_data_ready) begin
            valid_d = 1'b0;
            grant_d = '0;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            grant_q <= grant_d;
        end
    end

    assign o_data       = data_q;
    assign o_data_valid = valid_q;
    assign o_data_last  = last_q;
    assign o_grant      = grant_q;
    assign o_pkt_count  = cnt_q;

endmodule

// File: tb/tb_leaf_port_arbiter.sv
// Scoreboard bench for leaf_port_arbiter: directed stimulus pushes expected output beats,
// and a monitor pops and compares each beat as the downstream accepts it.
module tb_leaf_port_arbiter;

    localparam int NUM_IN = 5;
    localparam int DATA_W = 32;

    logic                     i_clk;
    logic                     i_reset;
    logic [NUM_IN*DATA_W-1:0] i_req_data;
    logic [NUM_IN-1:0]        i_req_valid;
    logic [NUM_IN-1:0]        i_req_last;
    logic [NUM_IN-1:0]        o_req_ready;
    logic [DATA_W-1:0]        o_data;
    logic                     o_data_valid;
    logic                     o_data_last;
    logic                     i_data_ready;
    logic [NUM_IN-1:0]        o_grant;
    logic [31:0]              o_pkt_count;

    int checks;
    int errors;
    // Expected beat: {data, last, grant}
    logic [DATA_W+NUM_IN:0] exp_q[$];

    leaf_port_arbiter #(
        .NUM_IN (NUM_IN),
        .DATA_W (DATA_W),
        .PTR_W  (3)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_req_data   (i_req_data),
        .i_req_valid  (i_req_valid),
        .i_req_last   (i_req_last),
        .o_req_ready  (o_req_ready),
        .o_data       (o_data),
        .o_data_valid (o_data_valid),
        .o_data_last  (o_data_last),
        .i_data_ready (i_data_ready),
        .o_grant      (o_grant),
        .o_pkt_count  (o_pkt_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a beat presented with downstream ready is consumed at the next edge.
    always @(negedge i_clk) begin
        logic [DATA_W+NUM_IN:0] e;
        if (!i_reset && o_data_valid && i_data_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard: unexpected beat data=%0h grant=%b", o_data, o_grant);
            end else begin
                e = exp_q.pop_front();
                if ({o_data, o_data_last, o_grant} !== e) begin
                    errors++;
                    $display("FAIL scoreboard: got data=%0h last=%b grant=%b expected data=%0h last=%b grant=%b",
                             o_data, o_data_last, o_grant, e[DATA_W+NUM_IN:NUM_IN+1],
                             e[NUM_IN], e[NUM_IN-1:0]);
                end
            end
        end
    end

    task automatic expect_beat(input logic [31:0] d, input logic l, input logic [4:0] g);
        exp_q.push_back({d, l, g});
    endtask

    task automatic set_in(input int k, input logic v, input logic [31:0] d, input logic l);
        i_req_valid[k]              = v;
        i_req_data[k*DATA_W +: DATA_W] = d;
        i_req_last[k]               = l;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_reset      = 1'b1;
        i_req_valid  = '1;
        i_req_last   = '1;
        i_req_data   = '0;
        i_data_ready = 1'b1;
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        check("rst_valid", 64'(o_data_valid), 64'd0);
        check("rst_data", 64'(o_data), 64'd0);
        check("rst_last", 64'(o_data_last), 64'd0);
        check("rst_grant", 64'(o_grant), 64'd0);
        check("rst_count", 64'(o_pkt_count), 64'd0);
        check("rst_ready", 64'(o_req_ready), 64'd0);
        i_req_valid = '0;
        i_req_last  = '0;
        #2 i_reset  = 1'b0;
    endtask

    task automatic drain(input string name);
        tick();
        tick();
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        i_reset      = 1'b1;
        i_req_valid  = '0;
        i_req_last   = '0;
        i_req_data   = '0;
        i_data_ready = 1'b1;

        // Single beat from input 2.
        do_reset();
        set_in(2, 1'b1, 32'hA2, 1'b1);
        #1 check("single_ready", 64'(o_req_ready), 64'b00100);
        expect_beat(32'hA2, 1'b1, 5'b00100);
        tick();
        set_in(2, 1'b0, 32'h0, 1'b0);
        check("single_valid", 64'(o_data_valid), 64'd1);
        check("single_count", 64'(o_pkt_count), 64'd1);
        drain("single_drain");

        // Fairness: all inputs always valid with single-beat packets.
        do_reset();
        for (int k = 0; k < NUM_IN; k++) set_in(k, 1'b1, 32'hF0 + 32'(k), 1'b1);
        for (int n = 0; n < 7; n++) expect_beat(32'hF0 + 32'(n % 5), 1'b1, 5'(1 << (n % 5)));
        for (int n = 0; n < 7; n++) begin
            tick();
            check("fair_nobubble", 64'(o_data_valid), 64'd1);
        end
        i_req_valid = '0;
        check("fair_count", 64'(o_pkt_count), 64'd7);
        drain("fair_drain");

        // Lock: 3-beat packet on input 1 blocks input 3.
        do_reset();
        set_in(1, 1'b1, 32'h11, 1'b0);
        set_in(3, 1'b1, 32'h31, 1'b1);
        expect_beat(32'h11, 1'b0, 5'b00010);
        expect_beat(32'h12, 1'b0, 5'b00010);
        expect_beat(32'h13, 1'b1, 5'b00010);
        expect_beat(32'h31, 1'b1, 5'b01000);
        #1 check("lock_ready0", 64'(o_req_ready), 64'b00010);
        tick();
        set_in(1, 1'b1, 32'h12, 1'b0);
        #1 check("lock_ready1", 64'(o_req_ready), 64'b00010);
        tick();
        set_in(1, 1'b1, 32'h13, 1'b1);
        #1 check("lock_ready2", 64'(o_req_ready), 64'b00010);
        tick();
        set_in(1, 1'b0, 32'h0, 1'b0);
        #1 check("lock_ready3", 64'(o_req_ready), 64'b01000);
        tick();
        set_in(3, 1'b0, 32'h0, 1'b0);
        check("lock_count", 64'(o_pkt_count), 64'd2);
        drain("lock_drain");

        // Backpressure: 0x55 held while downstream stalls, inputs 0 and 2 waiting.
        do_reset();
        i_data_ready = 1'b0;
        set_in(1, 1'b1, 32'h55, 1'b1);
        expect_beat(32'h55, 1'b1, 5'b00010);
        expect_beat(32'hA2, 1'b1, 5'b00100);
        expect_beat(32'hA0, 1'b1, 5'b00001);
        tick();
        set_in(1, 1'b0, 32'h0, 1'b0);
        set_in(0, 1'b1, 32'hA0, 1'b1);
        set_in(2, 1'b1, 32'hA2, 1'b1);
        for (int n = 0; n < 4; n++) begin
            #1;
            check("bp_ready", 64'(o_req_ready), 64'd0);
            check("bp_data", 64'(o_data), 64'h55);
            check("bp_grant", 64'(o_grant), 64'b00010);
            check("bp_valid", 64'(o_data_valid), 64'd1);
            tick();
        end
        i_data_ready = 1'b1;
        #1 check("bp_release_ready", 64'(o_req_ready), 64'b00100);
        tick();
        set_in(2, 1'b0, 32'h0, 1'b0);
        #1 check("bp_second_ready", 64'(o_req_ready), 64'b00001);
        tick();
        set_in(0, 1'b0, 32'h0, 1'b0);
        check("bp_count", 64'(o_pkt_count), 64'd3);
        drain("bp_drain");

        // Pointer wrap: after input 4 wins, input 0 precedes input 3.
        do_reset();
        set_in(4, 1'b1, 32'h44, 1'b1);
        expect_beat(32'h44, 1'b1, 5'b10000);
        expect_beat(32'h40, 1'b1, 5'b00001);
        expect_beat(32'h43, 1'b1, 5'b01000);
        tick();
        set_in(4, 1'b0, 32'h0, 1'b0);
        set_in(0, 1'b1, 32'h40, 1'b1);
        set_in(3, 1'b1, 32'h43, 1'b1);
        #1 check("wrap_ready0", 64'(o_req_ready), 64'b00001);
        tick();
        set_in(0, 1'b0, 32'h0, 1'b0);
        #1 check("wrap_ready3", 64'(o_req_ready), 64'b01000);
        tick();
        set_in(3, 1'b0, 32'h0, 1'b0);
        drain("wrap_drain");

        // Mid-packet reset: two of four beats of input 2, then reset between edges.
        do_reset();
        set_in(2, 1'b1, 32'h21, 1'b0);
        expect_beat(32'h21, 1'b0, 5'b00100);
        tick();
        set_in(2, 1'b1, 32'h22, 1'b0);
        tick();
        i_reset = 1'b1;
        #1;
        check("mid_valid", 64'(o_data_valid), 64'd0);
        check("mid_count", 64'(o_pkt_count), 64'd0);
        check("mid_ready", 64'(o_req_ready), 64'd0);
        @(posedge i_clk);
        #3 i_reset = 1'b0;
        set_in(0, 1'b1, 32'h01, 1'b1);
        set_in(2, 1'b1, 32'h23, 1'b1);
        expect_beat(32'h01, 1'b1, 5'b00001);
        expect_beat(32'h23, 1'b1, 5'b00100);
        #1 check("mid_first", 64'(o_req_ready), 64'b00001);
        tick();
        set_in(0, 1'b0, 32'h0, 1'b0);
        tick();
        set_in(2, 1'b0, 32'h0, 1'b0);
        check("mid_after_count", 64'(o_pkt_count), 64'd2);
        drain("mid_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/leaf_port_arbiter.md
Name: leaf_port_arbiter

Overview:
- Round-robin, packet-aware arbiter for one output port of the hierarchical leaf switch.
- Up to NUM_IN routed input streams compete for the port: four PE ports plus the centre uplink by default.
- Grant is held from a packet's first beat through its last beat.
- The winning beat goes into a single output register, giving one beat per cycle at full throughput with valid/ready flow control on both sides.

Parameters:
NUM_IN, 5, number of competing input streams; index 0 wins first after reset.
DATA_W, 32, flit width in bits.
PTR_W, 3, pointer/owner index width; must satisfy 2^PTR_W >= NUM_IN.

Ports:
i_clk  in  1  switch clock; all state on rising edge.
i_reset  in  1  asynchronous, active-high reset.
i_req_data  in  NUM_IN*DATA_W  input flits; input k occupies bits [k*DATA_W +: DATA_W].
i_req_valid  in  NUM_IN  per-input flit valid.
i_req_last  in  NUM_IN  per-input last-beat-of-packet flag; qualified by valid.
o_req_ready  out  NUM_IN  per-input ready; one-hot or zero.
o_data  out  DATA_W  output flit.
o_data_valid  out  1  output flit valid.
o_data_last  out  1  output last flag.
i_data_ready  in  1  downstream ready.
o_grant  out  NUM_IN  one-hot source of the flit held in the output register; zero when empty.
o_pkt_count  out  32  count of completed packets, i.e. last beats accepted on the input side.

Behaviour:
- Reset (async assert, sync-safe release) values:
  - o_data_valid=0, o_data=0, o_data_last=0, o_grant=0, o_pkt_count=0.
  - state=IDLE, pointer=0, owner=0.
  - o_req_ready is 0 while reset is asserted.
- Slot free: slot = !o_data_valid || i_data_ready (combinational).
- Beat transfer on input k: i_req_valid[k] && o_req_ready[k] at a rising edge.
- IDLE state:
  - Winner = first k with valid set, scanning pointer, pointer+1, ... modulo NUM_IN.
  - o_req_ready[winner] = slot; all other ready bits are 0.
  - On transfer with last=1: stay IDLE; pointer <= (winner+1) mod NUM_IN; o_pkt_count++.
  - On transfer with last=0: go to LOCKED with owner <= winner.
- LOCKED state:
  - o_req_ready[owner] = slot; all others are 0, regardless of their valid.
  - On owner transfer with last=1: go to IDLE; pointer <= (owner+1) mod NUM_IN; o_pkt_count++.
  - If the owner drops valid mid-packet: remain LOCKED indefinitely. There is no timeout and no other input is served.
- Output register:
  - On any transfer, capture data, last and one-hot source into o_data/o_data_last/o_grant, and set o_data_valid=1.
  - Otherwise, if i_data_ready=1, clear o_data_valid and o_grant.
  - Latency is 1 cycle from input transfer to o_data_valid.
  - Sustained throughput is 1 beat/cycle while i_data_ready=1.
- Output stability: o_data, o_data_last and o_grant must not change while o_data_valid=1 and i_data_ready=0.
- Ready dependency: o_req_ready depends combinationally on i_req_valid and i_data_ready. Requesters must not make valid depend on ready.
- Pointer: wraps from NUM_IN-1 to 0 and only advances on packet completion.
- Counter: o_pkt_count wraps from 2^32-1 to 0.
- Mid-packet reset:
  - All state clears immediately.
  - The partially transferred packet is abandoned; downstream sees valid drop asynchronously.
  - The first arbitration after reset starts from index 0.
- Single-beat packets: valid with last=1 never enters LOCKED.

Test Plan:
- Single beat: i_req_valid=5'b00100, data 0x000000A2, last=1, i_data_ready=1 -> o_req_ready=5'b00100 in the same cycle; next cycle o_data=0x000000A2, o_data_valid=1, o_grant=5'b00100, o_data_last=1; o_pkt_count=1.
- Fairness: all five inputs continuously valid with single-beat packets, ready=1 from reset release -> output sources 0,1,2,3,4,0,1 on consecutive cycles with no bubbles; o_pkt_count=7 after 7 transfers.
- Lock: input 1 sends a 3-beat packet (0x11,0x12,0x13, last on 0x13) while input 3 holds 0x31 with last=1 -> o_req_ready[3]=0 for three cycles; output order 0x11,0x12,0x13,0x31; o_grant sequence 00010,00010,00010,01000.
- Backpressure: output holding 0x55 while i_data_ready=0 for 4 cycles with inputs 0 and 2 valid -> o_req_ready=0, o_data stays 0x55. Release -> 0x55 consumed, then inputs 0 and 2 each appear exactly once, with no loss or duplication.
- Pointer wrap: last completed winner was 4, inputs 0 and 3 both valid -> input 0 wins first, then 3.
- Mid-packet reset: assert i_reset between edges after 2 of 4 beats of input 2 -> o_data_valid=0 immediately, o_pkt_count=0. After release, inputs 0 and 2 valid -> input 0 wins first.
